pulse_scheduler: RTL and testbench
==================================

// Module: pulse_scheduler
// PURPOSE
//  Shares one extended-pulse output between N_REQ requesters. Single-cycle request strobes are latched as pending.
//  A round-robin arbiter grants one pending requester at a time. It then drives o_x high for a run-time width,
//  followed by a fixed idle gap. Sits between trigger sources (counters, comparators) and the single pulse-driven output.
// PARAMETERS
//  N_REQ      4   number of requesters (>=2)
//  WIDTH_MAX  16  largest pulse width in cycles; i_width is $clog2(WIDTH_MAX+1) bits wide
//  GAP        1   forced low cycles after each pulse (0 allowed = back-to-back pulses)
// PORTS
//  clk         in   1                  clock, all logic on posedge
//  i_reset_n   in   1                  asynchronous, active-low reset
//  i_enable    in   1                  1 = new grants allowed; 0 = current pulse/gap finishes, no new grant
//  i_req       in   N_REQ              per-requester request strobe (level sampled every edge)
//  i_width     in   $clog2(WIDTH_MAX+1) pulse width, sampled only at grant
//  o_x         out  1                  shared extended pulse
//  o_busy      out  1                  state != IDLE
//  o_owner     out  $clog2(N_REQ)      index of current/last granted requester
//  o_pending   out  N_REQ              latched pending requests
//  o_done      out  N_REQ              one-cycle strobe: owner's pulse finished
//  o_overflow  out  N_REQ              one-cycle strobe: request merged into an already-pending one
// BEHAVIOUR
//  Reset (async, i_reset_n=0): state=IDLE, pend=0, cnt=0, last grant=N_REQ-1, owner=0.
//   - All outputs are 0 immediately, including o_x mid-pulse. A pulse cut by reset produces no o_done.
//  Pending: at each edge, pend[k] <= (pend[k] & ~clr[k]) | i_req[k].
//   - clr[k] is 1 only when k is granted at that edge.
//   - i_req[k]=1 at the grant edge of k leaves pend[k] set: it is a new request.
//   - o_overflow[k] (registered) =1 the cycle after an edge where i_req[k]=1, pend[k]=1 and clr[k]=0.
//  Arbiter: round-robin. The search starts at (last grant + 1) mod N_REQ, wrap-around.
//   - After reset, requester 0 has highest priority.
//   - A requester pending together with others waits at most N_REQ-1 grants.
//  FSM states IDLE, PULSE, GAP:
//   - IDLE -> PULSE: edge with i_enable=1 and pend!=0.
//       Latch owner, last grant=owner, clear pend[owner], cnt <= max(i_width,1)-1.
//       i_width=0 is treated as 1. i_width>WIDTH_MAX is clamped to WIDTH_MAX.
//   - PULSE: cnt decrements each edge. When cnt==0: -> GAP if GAP>0, else -> IDLE.
//       cnt is reloaded with GAP-1 on the GAP transition.
//   - GAP: cnt decrements. When cnt==0: -> IDLE.
//   - GAP=0 with a pending request: IDLE takes one cycle, so there is always >=1 low cycle between pulses.
//   - No transition out of PULSE or GAP except reset; i_enable is ignored there.
//  Outputs:
//   - o_x = (state==PULSE), registered state decode, no combinational path from inputs.
//   - Latency: i_req at edge E0 -> pend set after E0 -> grant at E1 -> o_x high after E1.
//     o_x stays high exactly W cycles (W = effective width).
//   - o_done[owner]=1 for the single cycle following the last o_x high cycle.
//   - o_owner holds its value until the next grant.
//  Width rules: cnt is $clog2(WIDTH_MAX+1) bits wide, never underflows, unsigned compare only.
//  Simultaneous events:
//   - Request from the current owner during its pulse: becomes pending and is served after other pending requesters.
//   - i_enable falling during PULSE: pulse completes at full width.
// TESTING
//  1 Reset; i_req=0001 one cycle, i_width=3 -> o_x high 3 cycles starting 2 cycles after strobe; o_done=0001 next cycle; o_busy low after gap.
//  2 i_req=1111 same cycle, i_width=2, GAP=1 -> grants 0,1,2,3 in order; o_x pattern 11 0 0 11 0 0... (gap + idle); pend drains to 0.
//  3 i_width=0 -> 1-cycle pulse; i_width=WIDTH_MAX+ (all ones) -> WIDTH_MAX-cycle pulse.
//  4 Hold i_req[2]=1 two cycles while pend[2] set and not granted -> o_overflow=0100 one cycle; only one pulse for requester 2 after merge.
//  5 Pulse of width 8, drop i_reset_n at cycle 4 -> o_x=0 immediately; no o_done; after release requester 0 wins first.
//  6 i_enable=0 with pend=0010 -> no o_x; raise i_enable -> grant on next edge. Deassert i_enable mid-pulse -> full width still delivered.

Source files
------------

// File: rtl/pulse_scheduler.sv
// ============================================================================
// Module      : pulse_scheduler
// Description : Round-robin sharing of one extended-pulse output among
//               N_REQ strobe requesters, with a fixed idle gap per pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_scheduler #(
  parameter int N_REQ     = 4,
  parameter int WIDTH_MAX = 16,
  parameter int GAP       = 1
) (
  input  logic                           clk,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic [N_REQ-1:0]               i_req,
  input  logic [$clog2(WIDTH_MAX+1)-1:0] i_width,
  output logic                           o_x,
  output logic                           o_busy,
  output logic [$clog2(N_REQ)-1:0]       o_owner,
  output logic [N_REQ-1:0]               o_pending,
  output logic [N_REQ-1:0]               o_done,
  output logic [N_REQ-1:0]               o_overflow
);

  localparam int c_ww       = $clog2(WIDTH_MAX + 1);
  localparam int c_ow       = $clog2(N_REQ);
  // Counter also has to hold GAP-1 should GAP ever exceed WIDTH_MAX.
  localparam int c_cw       = (GAP > WIDTH_MAX) ? $clog2(GAP + 1) : c_ww;
  localparam int c_gap_load = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_pulse = 2'd1;
  localparam logic [1:0] c_st_gap   = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_cw-1:0]  r_cnt;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_done;
  logic [N_REQ-1:0] r_overflow;
  logic [c_ow-1:0]  r_last;
  logic [c_ow-1:0]  r_owner;

  logic             w_gnt_valid;
  logic [c_ow-1:0]  w_gnt_idx;
  logic             w_grant;
  logic [N_REQ-1:0] w_clr;
  logic [c_ww-1:0]  w_wid_eff;
  logic             w_cnt_zero;

  // Round-robin search from last+1; descending offsets so the nearest wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(r_last) + off) % N_REQ;
      if (r_pend[c_ow'(idx)]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = c_ow'(idx);
      end
    end
  end

  assign w_grant    = (r_state == c_st_idle) && i_enable && w_gnt_valid;
  assign w_clr      = w_grant ? (N_REQ'(1) << w_gnt_idx) : '0;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    if (i_width == '0)
      w_wid_eff = c_ww'(1);
    else if (i_width > c_ww'(WIDTH_MAX))
      w_wid_eff = c_ww'(WIDTH_MAX);
    else
      w_wid_eff = i_width;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= c_st_idle;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_grant) w_state_nxt = c_st_pulse;
      c_st_pulse: if (w_cnt_zero) w_state_nxt = (GAP > 0) ? c_st_gap : c_st_idle;
      c_st_gap:   if (w_cnt_zero) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    o_x    = (r_state == c_st_pulse);
    o_busy = (r_state != c_st_idle);
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pend     <= '0;
      r_cnt      <= '0;
      r_last     <= c_ow'(N_REQ - 1);
      r_owner    <= '0;
      r_done     <= '0;
      r_overflow <= '0;
    end else begin
      r_pend     <= (r_pend & ~w_clr) | i_req;
      r_overflow <= i_req & r_pend & ~w_clr;
      r_done     <= (r_state == c_st_pulse && w_cnt_zero) ? (N_REQ'(1) << r_owner) : '0;
      if (w_grant) begin
        r_owner <= w_gnt_idx;
        r_last  <= w_gnt_idx;
      end
      case (r_state)
        c_st_idle:  if (w_grant) r_cnt <= c_cw'(w_wid_eff - c_ww'(1));
        c_st_pulse: r_cnt <= w_cnt_zero ? c_cw'(c_gap_load) : r_cnt - c_cw'(1);
        c_st_gap:   if (!w_cnt_zero) r_cnt <= r_cnt - c_cw'(1);
        default:    r_cnt <= '0;
      endcase
    end
  end

  assign o_owner    = r_owner;
  assign o_pending  = r_pend;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_pulse_scheduler.sv
// ============================================================================
// Module      : tb_pulse_scheduler
// Description : Directed bench for pulse_scheduler with a pulse scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_scheduler;

  localparam int N_REQ     = 4;
  localparam int WIDTH_MAX = 16;
  localparam int GAP       = 1;

  logic       clk;
  logic       i_reset_n;
  logic       i_enable;
  logic [3:0] i_req;
  logic [4:0] i_width;
  logic       o_x;
  logic       o_busy;
  logic [1:0] o_owner;
  logic [3:0] o_pending;
  logic [3:0] o_done;
  logic [3:0] o_overflow;

  pulse_scheduler #(.N_REQ(N_REQ), .WIDTH_MAX(WIDTH_MAX), .GAP(GAP)) dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_req      (i_req),
    .i_width    (i_width),
    .o_x        (o_x),
    .o_busy     (o_busy),
    .o_owner    (o_owner),
    .o_pending  (o_pending),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int width;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int owner, input int width);
    exp_t e;
    e.owner = owner;
    e.width = width;
    sb.push_back(e);
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!o_busy && o_pending == 4'd0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic wait_not_busy(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!o_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic reset_dut();
    i_reset_n = 1'b0;
    i_req     = 4'd0;
    tick();
    tick();
    check("rst_x",        32'(o_x), 0);
    check("rst_busy",     32'(o_busy), 0);
    check("rst_owner",    32'(o_owner), 0);
    check("rst_pending",  32'(o_pending), 0);
    check("rst_done",     32'(o_done), 0);
    check("rst_overflow", 32'(o_overflow), 0);
    i_reset_n = 1'b1;
  endtask

  // Scoreboard monitor: measures each completed pulse and compares to queue.
  logic in_pulse = 1'b0;
  int   width_cnt = 0;
  int   cur_owner = 0;

  always @(negedge clk) begin
    if (!i_reset_n) begin
      in_pulse  = 1'b0;
      width_cnt = 0;
    end else if (o_x) begin
      if (!in_pulse) begin
        in_pulse  = 1'b1;
        width_cnt = 0;
        cur_owner = int'(o_owner);
      end
      width_cnt++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      check("sb_pulse_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_owner", 32'(cur_owner), 32'(e.owner));
        check("sb_width", 32'(width_cnt), 32'(e.width));
        check("sb_done",  32'(o_done), 32'(1) << e.owner);
      end
    end
  end

  initial begin
    logic [15:0] pat;
    i_reset_n = 1'b0;
    i_enable  = 1'b1;
    i_req     = 4'd0;
    i_width   = 5'd0;

    // Single request, width 3
    reset_dut();
    i_width = 5'd3;
    expect_pulse(0, 3);
    i_req = 4'b0001;
    tick();
    i_req = 4'd0;
    check("t1_pend_set", 32'(o_pending), 1);
    check("t1_x_lat0",   32'(o_x), 0);
    tick();
    check("t1_x_hi",     32'(o_x), 1);
    check("t1_pend_clr", 32'(o_pending), 0);
    tick();
    tick();
    check("t1_x_hi3",    32'(o_x), 1);
    tick();
    check("t1_x_lo",     32'(o_x), 0);
    check("t1_done",     32'(o_done), 1);
    check("t1_gap_busy", 32'(o_busy), 1);
    tick();
    check("t1_idle",     32'(o_busy), 0);
    check("t1_done_clr", 32'(o_done), 0);

    // All four at once: round-robin order and 11 0 0 spacing
    reset_dut();
    i_width = 5'd2;
    for (int k = 0; k < 4; k++) expect_pulse(k, 2);
    i_req = 4'b1111;
    tick();
    i_req = 4'd0;
    check("t2_pend_all", 32'(o_pending), 15);
    tick();
    check("t2_owner0",   32'(o_owner), 0);
    check("t2_pend_rem", 32'(o_pending), 14);
    for (int i = 0; i < 16; i++) begin
      pat[15-i] = o_x;
      tick();
    end
    check("t2_pattern", 32'(pat), 32'h0000_cccc);
    check("t2_drained", 32'(o_pending), 0);
    check("t2_idle",    32'(o_busy), 0);

    // Width boundaries: 0 -> 1 cycle, all ones -> WIDTH_MAX
    i_width = 5'd0;
    expect_pulse(1, 1);
    i_req = 4'b0010;
    tick();
    i_req = 4'd0;
    wait_idle("t3_idle_w0");
    i_width = 5'd31;
    expect_pulse(3, WIDTH_MAX);
    i_req = 4'b1000;
    tick();
    i_req = 4'd0;
    tick();
    check("t3_x_hi", 32'(o_x), 1);
    wait_idle("t3_idle_wmax");

    // Overflow: requester 2 strobes twice while pending
    i_width = 5'd4;
    expect_pulse(0, 4);
    expect_pulse(2, 4);
    i_req = 4'b0001;
    tick();
    i_req = 4'd0;
    tick();
    i_req = 4'b0100;
    tick();
    check("t4_ovf_first", 32'(o_overflow), 0);
    tick();
    i_req = 4'd0;
    check("t4_ovf",      32'(o_overflow), 4);
    check("t4_pend",     32'(o_pending), 4);
    tick();
    check("t4_ovf_clr",  32'(o_overflow), 0);
    wait_idle("t4_idle");

    // Reset mid-pulse: no done, requester 0 first afterwards
    i_width = 5'd8;
    i_req = 4'b0010;
    tick();
    i_req = 4'd0;
    tick();
    tick();
    tick();
    tick();
    check("t5_x_pre", 32'(o_x), 1);
    #1 i_reset_n = 1'b0;
    #1;
    check("t5_x_async",    32'(o_x), 0);
    check("t5_busy_async", 32'(o_busy), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t5_no_done", 32'(o_done), 0);
    end
    i_reset_n = 1'b1;
    i_width = 5'd1;
    for (int k = 0; k < 4; k++) expect_pulse(k, 1);
    i_req = 4'b1111;
    tick();
    i_req = 4'd0;
    tick();
    check("t5_first_owner", 32'(o_owner), 0);
    wait_idle("t5_idle");

    // Enable gating and mid-pulse disable
    i_enable = 1'b0;
    i_width  = 5'd5;
    i_req    = 4'b0010;
    tick();
    i_req = 4'd0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_x",   32'(o_x), 0);
      check("t6_held",   32'(o_pending), 2);
      tick();
    end
    expect_pulse(1, 5);
    i_enable = 1'b1;
    tick();
    check("t6_x_grant", 32'(o_x), 1);
    check("t6_owner",   32'(o_owner), 1);
    tick();
    tick();
    i_enable = 1'b0;
    i_req    = 4'b1000;
    tick();
    i_req = 4'd0;
    wait_not_busy("t6_pulse_end");
    for (int i = 0; i < 3; i++) begin
      check("t6_dis_no_x", 32'(o_x), 0);
      check("t6_dis_held", 32'(o_pending), 8);
      tick();
    end
    expect_pulse(3, 5);
    i_enable = 1'b1;
    tick();
    wait_idle("t6_idle");

    tick();
    tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
